// File: rtl/fwd_hazard_unit_pkg.sv
// Shared core package: forwarding select encoding, per-stage destination info
// and the hard-wired zero register index used by the forwarding/hazard logic.
package fwd_hazard_unit_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_NONE    = 2'b00,
        FWD_MEM_ALU = 2'b01,
        FWD_WB      = 2'b10,
        FWD_MEM_LD  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 wr;
        logic                 ld;
    } stage_info_t;

endpackage

// File: rtl/fwd_sel_logic.sv
// Forwarding select for one EX-stage source operand.
// MEM has priority over WB; x0 is never forwarded. A load sitting in MEM is
// only forwarded when LOAD_FWD is set, otherwise that source gets no forward.
module fwd_sel_logic
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LOAD_FWD   = 1
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  src_used,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_wr,
    input  logic                  mem_ld,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_wr,
    output logic [1:0]            sel
);

    logic     mem_hit;
    logic     wb_hit;
    fwd_sel_e sel_e;

    assign mem_hit = src_used && mem_wr && (mem_rd != REG_ZERO) && (mem_rd == src);
    assign wb_hit  = src_used && wb_wr  && (wb_rd  != REG_ZERO) && (wb_rd  == src);

    // Priority select: MEM hit first, then WB, else register file / immediate
    always_comb begin
        sel_e = FWD_NONE;
        if (mem_hit) begin
            if (!mem_ld) begin
                sel_e = FWD_MEM_ALU;
            end else if (LOAD_FWD != 0) begin
                sel_e = FWD_MEM_LD;
            end else begin
                sel_e = FWD_NONE;
            end
        end else if (wb_hit) begin
            sel_e = FWD_WB;
        end
    end

    assign sel = sel_e;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard controller for the 5-stage core.
// Tracks destination/control info for EX, MEM and WB, drives the EX-stage
// src1/src2 forwarding selects and the load-use stall / EX bubble.
// Optional macro FWD_PERF_CNT_EN adds fwd_cnt / stall_cnt event counters.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LOAD_FWD   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_alu_src,
    input  logic                  pipe_stall,
    input  logic                  flush,
    output logic [1:0]            rs_sel,
    output logic [1:0]            rt_sel,
    output logic                  load_use_stall,
    output logic                  ex_bubble
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]           fwd_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    // EX shadow stage
    stage_info_t           ex_info;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic                  ex_rs1_used;
    logic                  ex_rs2_used;
    logic                  ex_alu_src;
    logic                  ex_valid;

    // MEM and WB shadow stages
    stage_info_t           mem_info;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_wr;

    logic                  ex_insert_bubble;
    logic                  rs_src_used;
    logic                  rt_src_used;

    // An immediate src2 never takes a forward, so rt is treated as unused
    assign rs_src_used = ex_valid && ex_rs1_used;
    assign rt_src_used = ex_valid && ex_rs2_used && !ex_alu_src;

    fwd_sel_logic #(
        .REG_ADDR_W (REG_ADDR_W),
        .LOAD_FWD   (LOAD_FWD)
    ) u_rs_sel (
        .src      (ex_rs1),
        .src_used (rs_src_used),
        .mem_rd   (mem_info.rd),
        .mem_wr   (mem_info.wr),
        .mem_ld   (mem_info.ld),
        .wb_rd    (wb_rd),
        .wb_wr    (wb_wr),
        .sel      (rs_sel)
    );

    fwd_sel_logic #(
        .REG_ADDR_W (REG_ADDR_W),
        .LOAD_FWD   (LOAD_FWD)
    ) u_rt_sel (
        .src      (ex_rs2),
        .src_used (rt_src_used),
        .mem_rd   (mem_info.rd),
        .mem_wr   (mem_info.wr),
        .mem_ld   (mem_info.ld),
        .wb_rd    (wb_rd),
        .wb_wr    (wb_wr),
        .sel      (rt_sel)
    );

    // Load in EX feeding a used ID source: hold ID one cycle (stall mode only)
    always_comb begin
        load_use_stall = 1'b0;
        if (LOAD_FWD == 0) begin
            load_use_stall = id_valid && ex_info.ld && ex_info.wr &&
                             (ex_info.rd != REG_ZERO) &&
                             ((id_rs1_used && (id_rs1 == ex_info.rd)) ||
                              (id_rs2_used && (id_rs2 == ex_info.rd))) &&
                             !flush && !pipe_stall;
        end
    end

    assign ex_bubble        = (load_use_stall || flush) && !pipe_stall;
    assign ex_insert_bubble = flush || load_use_stall || !id_valid;

    // Shadow pipeline advance; frozen while the whole core is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_info     <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rs1_used <= 1'b0;
            ex_rs2_used <= 1'b0;
            ex_alu_src  <= 1'b0;
            ex_valid    <= 1'b0;
            mem_info    <= '0;
            wb_rd       <= '0;
            wb_wr       <= 1'b0;
        end else if (!pipe_stall) begin
            if (ex_insert_bubble) begin
                ex_info     <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_rs1_used <= 1'b0;
                ex_rs2_used <= 1'b0;
                ex_alu_src  <= 1'b0;
                ex_valid    <= 1'b0;
            end else begin
                ex_info.rd  <= id_rd;
                ex_info.wr  <= id_reg_write;
                ex_info.ld  <= id_mem_read;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rs1_used <= id_rs1_used;
                ex_rs2_used <= id_rs2_used;
                ex_alu_src  <= id_alu_src;
                ex_valid    <= 1'b1;
            end
            mem_info <= ex_info;
            wb_rd    <= mem_info.rd;
            wb_wr    <= mem_info.wr;
        end
    end

`ifdef FWD_PERF_CNT_EN
    // Event counters: forwarding cycles and load-use stall cycles, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (!pipe_stall && ((rs_sel != FWD_NONE) || (rt_sel != FWD_NONE))) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
            if (load_use_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: one instance with load forwarding,
// one with load-use stalling, driven by directed instruction sequences.
// Expected {rs_sel, rt_sel, load_use_stall, ex_bubble} go through a scoreboard.
module tb_fwd_hazard_unit;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       alu_src;
    } instr_t;

    typedef struct {
        int unsigned dut;
        logic [5:0]  exp;
        string       tag;
    } sb_t;

    localparam instr_t NOP_I = '0;

    logic       clk = 1'b0;
    logic       rst;
    instr_t     id_in  [2];
    logic       pstall [2];
    logic       fl     [2];
    logic [1:0] rs_sel [2];
    logic [1:0] rt_sel [2];
    logic       lus    [2];
    logic       bub    [2];

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .REG_ADDR_W (5),
        .LOAD_FWD   (1)
    ) u_dut_ldfwd (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_in[0].valid),
        .id_rs1         (id_in[0].rs1),
        .id_rs2         (id_in[0].rs2),
        .id_rs1_used    (id_in[0].u1),
        .id_rs2_used    (id_in[0].u2),
        .id_rd          (id_in[0].rd),
        .id_reg_write   (id_in[0].wr),
        .id_mem_read    (id_in[0].ld),
        .id_alu_src     (id_in[0].alu_src),
        .pipe_stall     (pstall[0]),
        .flush          (fl[0]),
        .rs_sel         (rs_sel[0]),
        .rt_sel         (rt_sel[0]),
        .load_use_stall (lus[0]),
        .ex_bubble      (bub[0])
    );

    fwd_hazard_unit #(
        .REG_ADDR_W (5),
        .LOAD_FWD   (0)
    ) u_dut_ldstall (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_in[1].valid),
        .id_rs1         (id_in[1].rs1),
        .id_rs2         (id_in[1].rs2),
        .id_rs1_used    (id_in[1].u1),
        .id_rs2_used    (id_in[1].u2),
        .id_rd          (id_in[1].rd),
        .id_reg_write   (id_in[1].wr),
        .id_mem_read    (id_in[1].ld),
        .id_alu_src     (id_in[1].alu_src),
        .pipe_stall     (pstall[1]),
        .flush          (fl[1]),
        .rs_sel         (rs_sel[1]),
        .rt_sel         (rt_sel[1]),
        .load_use_stall (lus[1]),
        .ex_bubble      (bub[1])
    );

    function automatic instr_t op_rr(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
        instr_t i;
        i         = '0;
        i.valid   = 1'b1;
        i.rs1     = rs1;
        i.rs2     = rs2;
        i.u1      = 1'b1;
        i.u2      = 1'b1;
        i.rd      = rd;
        i.wr      = 1'b1;
        return i;
    endfunction

    // Immediate form; rs2 field stays marked used so the immediate override is exercised
    function automatic instr_t op_ri(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2_field);
        instr_t i;
        i         = op_rr(rd, rs1, rs2_field);
        i.alu_src = 1'b1;
        return i;
    endfunction

    function automatic instr_t op_ld(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i;
        i         = op_rr(rd, rs1, 5'd0);
        i.u2      = 1'b0;
        i.ld      = 1'b1;
        i.alu_src = 1'b1;
        return i;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, obs[5:0], exp[5:0]);
        end
    endtask

    // Pop the oldest expectation and compare against the addressed instance
    task automatic sb_compare();
        sb_t        e;
        logic [5:0] obs;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e   = sb_q.pop_front();
            obs = {rs_sel[e.dut], rt_sel[e.dut], lus[e.dut], bub[e.dut]};
            check_eq(e.tag, {26'd0, obs}, {26'd0, e.exp});
        end
    endtask

    // Drive one ID-stage cycle on instance d (other idles), check, then clock
    task automatic step(input int unsigned d, input instr_t ins, input logic stl,
                        input logic flsh, input logic r, input logic [5:0] exp,
                        input string tag);
        sb_t e;
        for (int unsigned k = 0; k < 2; k++) begin
            id_in[k]  = NOP_I;
            pstall[k] = 1'b0;
            fl[k]     = 1'b0;
        end
        id_in[d]  = ins;
        pstall[d] = stl;
        fl[d]     = flsh;
        rst       = r;
        e.dut     = d;
        e.exp     = exp;
        e.tag     = tag;
        sb_q.push_back(e);
        #2;
        sb_compare();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int unsigned k = 0; k < 2; k++) begin
            id_in[k]  = NOP_I;
            pstall[k] = 1'b0;
            fl[k]     = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // --- LOAD_FWD = 1 instance ---
        step(0, op_rr(5'd5, 5'd1, 5'd2),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "rst_ldfwd");
        step(0, op_rr(5'd6, 5'd5, 5'd7),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "alu_pre");
        step(0, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b01_00_00, "mem_alu_rs");
        step(0, op_rr(5'd5, 5'd1, 5'd2),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "nop_ex");
        step(0, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b00_00_00, "no_hit");
        step(0, op_rr(5'd8, 5'd1, 5'd5),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "wb_pre");
        step(0, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b00_10_00, "wb_rt");
        step(0, op_rr(5'd5, 5'd1, 5'd2),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "prio_pre0");
        step(0, op_rr(5'd5, 5'd3, 5'd4),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "prio_pre1");
        step(0, op_rr(5'd8, 5'd1, 5'd5),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "prio_pre2");
        step(0, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b00_01_00, "mem_over_wb");
        step(0, op_ld(5'd3, 5'd1),        1'b0, 1'b0, 1'b0, 6'b00_00_00, "ld_pre");
        step(0, op_rr(5'd4, 5'd3, 5'd3),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "ld_no_stall");
        step(0, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b11_11_00, "mem_ld_fwd");
        step(0, op_rr(5'd0, 5'd1, 5'd2),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "x0_pre0");
        step(0, op_rr(5'd0, 5'd3, 5'd4),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "x0_pre1");
        step(0, op_rr(5'd9, 5'd0, 5'd0),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "x0_pre2");
        step(0, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b00_00_00, "x0_no_fwd");
        step(0, op_rr(5'd10, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 6'b00_00_00, "imm_pre0");
        step(0, op_ri(5'd11, 5'd10, 5'd10), 1'b0, 1'b0, 1'b0, 6'b00_00_00, "imm_pre1");
        step(0, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b01_00_00, "imm_rt_none");
        step(0, op_rr(5'd12, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 6'b00_00_00, "frz_pre0");
        step(0, op_rr(5'd13, 5'd12, 5'd12), 1'b0, 1'b0, 1'b0, 6'b00_00_00, "frz_pre1");
        for (int i = 0; i < 3; i++) begin
            step(0, NOP_I,                1'b1, 1'b0, 1'b0, 6'b01_01_00, "frozen");
        end
        step(0, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b01_01_00, "frz_release");
        step(0, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b00_00_00, "frz_advance");

        // --- LOAD_FWD = 0 instance ---
        step(1, op_ld(5'd3, 5'd1),        1'b0, 1'b0, 1'b0, 6'b00_00_00, "rst_ldstall");
        step(1, op_rr(5'd4, 5'd3, 5'd3),  1'b0, 1'b0, 1'b0, 6'b00_00_11, "lu_stall");
        step(1, op_rr(5'd4, 5'd3, 5'd3),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "lu_once");
        step(1, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b10_10_00, "lu_wb_fwd");
        step(1, op_ld(5'd3, 5'd1),        1'b0, 1'b0, 1'b0, 6'b00_00_00, "b2b_pre");
        step(1, op_ld(5'd3, 5'd3),        1'b0, 1'b0, 1'b0, 6'b00_00_11, "b2b_stall0");
        step(1, op_ld(5'd3, 5'd3),        1'b0, 1'b0, 1'b0, 6'b00_00_00, "b2b_held0");
        step(1, op_rr(5'd4, 5'd3, 5'd1),  1'b0, 1'b0, 1'b0, 6'b10_00_11, "b2b_stall1");
        step(1, op_rr(5'd4, 5'd3, 5'd1),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "b2b_held1");
        step(1, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b10_00_00, "b2b_wb_fwd");
        step(1, op_ld(5'd7, 5'd1),        1'b0, 1'b0, 1'b0, 6'b00_00_00, "fl_pre");
        step(1, op_rr(5'd8, 5'd7, 5'd2),  1'b0, 1'b1, 1'b0, 6'b00_00_01, "flush_wins");
        step(1, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b00_00_00, "flush_killed");
        step(1, op_ld(5'd7, 5'd1),        1'b0, 1'b0, 1'b0, 6'b00_00_00, "ps_pre");
        step(1, op_rr(5'd8, 5'd7, 5'd2),  1'b1, 1'b0, 1'b0, 6'b00_00_00, "ps_gates_stall");
        step(1, op_rr(5'd8, 5'd7, 5'd2),  1'b0, 1'b0, 1'b0, 6'b00_00_11, "ps_then_stall");
        step(1, op_rr(5'd8, 5'd7, 5'd2),  1'b0, 1'b0, 1'b0, 6'b00_00_00, "ps_held");
        step(1, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b10_00_00, "ps_wb_fwd");

        // --- reset mid-stream, asserted together with pipe_stall ---
        step(0, op_rr(5'd14, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 6'b00_00_00, "mr_pre0");
        step(0, op_rr(5'd15, 5'd14, 5'd14), 1'b0, 1'b0, 1'b0, 6'b00_00_00, "mr_pre1");
        step(0, NOP_I,                    1'b1, 1'b0, 1'b1, 6'b01_01_00, "mr_before");
        step(0, NOP_I,                    1'b1, 1'b0, 1'b0, 6'b00_00_00, "mr_after");
        step(0, NOP_I,                    1'b0, 1'b0, 1'b0, 6'b00_00_00, "mr_settled");

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Operand forwarding and hazard controller for the 5-stage RISC-V core.
- Keeps a shadow pipeline of destination and control info for the EX, MEM and WB stages.
- Drives the EX-stage src1/src2 forwarding mux selects and the load-use stall/bubble signals.
- Sits directly upstream of the src2 forwarding mux and its src1 twin.

Parameters:
- REG_ADDR_W, 5, register index width.
- LOAD_FWD, 1, 1 = load data forwarded from MEM (sel 11, no stall); 0 = load-use stall of one cycle, then forwarding from WB.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  REG_ADDR_W  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- id_alu_src  in  1  ID instruction uses an immediate as src2
- pipe_stall  in  1  global freeze (Dcache/Icache miss)
- flush  in  1  taken branch/jump; kill ID
- rs_sel  out  2  src1 select
- rt_sel  out  2  src2 select
- load_use_stall  out  1  hold PC and IF/ID
- ex_bubble  out  1  EX receives a NOP this cycle

Behaviour:
- Select encoding for rs_sel and rt_sel:
  - 00: no forward (immediate or register-file path).
  - 01: MEM ALU result.
  - 10: WB write_data.
  - 11: MEM Dcache_out_ext.
- Shadow registers:
  - EX stage: rd, wr, ld, rs1, rs2, rs1_used, rs2_used, alu_src, valid.
  - MEM stage: rd, wr, ld.
  - WB stage: rd, wr.
- Reset (rst=1 at posedge): clear every shadow register to 0, which gives no write, invalid, x0.
  - Outputs after reset: rs_sel=00, rt_sel=00, load_use_stall=0, ex_bubble=0.
- Update at each posedge when not in reset:
  - pipe_stall=1: all shadow registers hold. Selects keep their value. load_use_stall and ex_bubble are forced to 0.
  - Otherwise:
    - EX <= bubble if (flush | load_use_stall | !id_valid); else EX <= ID fields.
    - MEM <= EX.
    - WB <= MEM.
- Selects are combinational from the shadow state and describe the instruction currently in EX.
  - Source hit on MEM: src_used_EX and wr_MEM and rd_MEM != 0 and rd_MEM == src_EX.
    - Gives 11 if ld_MEM (only when LOAD_FWD=1), else 01.
  - Otherwise, source hit on WB (same test against the WB registers): gives 10.
  - Otherwise: 00.
  - MEM has priority over WB when both match.
  - rt_sel is forced to 00 when alu_src_EX=1.
  - x0 is never forwarded.
- load_use_stall (combinational, LOAD_FWD=0 only):
  - Asserted when id_valid, ld_EX, wr_EX and rd_EX != 0 and rd_EX matches a used ID source.
  - Gated by !flush and !pipe_stall.
  - Always 0 when LOAD_FWD=1.
- ex_bubble = (load_use_stall | flush) & !pipe_stall.
- Boundary cases:
  - Stall and flush together: flush wins; no stall.
  - Back-to-back loads to the same rd: each dependent instruction stalls once (LOAD_FWD=0).
  - LOAD_FWD=0 with a load in MEM matching EX: cannot occur after the stall. If it is forced anyway, select 01 is never produced for a load; the result is 00.
  - Reset during pipe_stall: reset wins.
- Latency: zero-cycle combinational selects. Shadow state advances one stage per unstalled cycle.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- Defined:
  - Adds two outputs, fwd_cnt (32) and stall_cnt (32).
  - fwd_cnt increments once per unstalled cycle in which rs_sel or rt_sel is nonzero.
  - stall_cnt increments per cycle with load_use_stall=1.
  - Both wrap at 2^32-1 to 0 and clear on rst.
- Undefined: no counters and no extra ports. All other behaviour is identical.

Decomposition:
- Add to the shared core package:
  - typedef fwd_sel_e with FWD_NONE=00, FWD_MEM_ALU=01, FWD_WB=10, FWD_MEM_LD=11.
  - Struct stage_info_t {rd, wr, ld}.
  - Constant REG_ZERO.
- One sub-module, fwd_sel_logic: pure combinational select for one source. Instantiate it twice, for rs and for rt.

Test Plan:
- ADD x5 then ADD x6,x5,x7 → next cycle rs_sel=01 for x5 and rt_sel=00.
- ADD x5, NOP, SUB x8,x1,x5 → rt_sel=10; with both MEM and WB writing x5, rt_sel=01.
- LOAD_FWD=1: LW x3 then ADD x4,x3,x3 → no stall; rs_sel=rt_sel=11.
- LOAD_FWD=0, same sequence → load_use_stall=1 and ex_bubble=1 for exactly one cycle, then rs_sel=rt_sel=10.
- Writes to x0 followed by readers of x0 → selects stay 00. ADDI with alu_src=1 matching MEM rd → rt_sel=00, rs_sel per rs1.
- pipe_stall held 3 cycles during a pending forward → selects unchanged and shadow frozen. Then flush with a load-use hit → no stall, bubble=1. rst mid-stream → all outputs 0 next cycle.
